// File: rtl/single_rf_pkg.sv
// Shared constants, field type and access decode for the single_rf register file.
package single_rf_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned ADDR_MSB      = 3;
  localparam int unsigned ADDR_LSB      = 3;
  localparam int unsigned INFO_REG_ADDR = 0;

  localparam logic [DATA_WIDTH-1:0] RESET_VALUE = '0;

  typedef logic [DATA_WIDTH-1:0] info_field_t;

  typedef enum logic [1:0] {
    AccNone,
    AccRead,
    AccWrite,
    AccInvalid
  } access_e;

  // A simultaneous read and write to a mapped address counts as a write.
  function automatic access_e decode_access(input logic i_rd, input logic i_wr,
                                            input logic i_hit);
    if (!(i_rd || i_wr)) return AccNone;
    if (!i_hit)          return AccInvalid;
    if (i_wr)            return AccWrite;
    return AccRead;
  endfunction

endpackage

// File: rtl/rf_field_reg.sv
// One software/hardware field register; a software write beats a hardware load.
module rf_field_reg #(
  parameter int unsigned            WIDTH       = 64,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_sw_we,
  input  logic [WIDTH-1:0] i_sw_wdata,
  input  logic             i_hw_we,
  input  logic [WIDTH-1:0] i_hw_wdata,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_value <= RESET_VALUE;
    end else if (i_sw_we) begin
      r_value <= i_sw_wdata;
    end else if (i_hw_we) begin
      r_value <= i_hw_wdata;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/single_rf.sv
// Register file with one 64-bit register (info_reg.info_field) behind a simple sw bus.
// Define SINGLERF_RDATA_CLEAR_EN to zero read_data in every cycle without a valid read.
module single_rf
  import single_rf_pkg::*;
#(
  parameter int unsigned                 DATA_WIDTH  = single_rf_pkg::DATA_WIDTH,
  parameter int unsigned                 ADDR_MSB    = single_rf_pkg::ADDR_MSB,
  parameter int unsigned                 ADDR_LSB    = single_rf_pkg::ADDR_LSB,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE = single_rf_pkg::RESET_VALUE
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [ADDR_MSB:ADDR_LSB] address,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  access_complete,
  output logic                  invalid_address,
  output logic [DATA_WIDTH-1:0] info_reg_info_field,
  input  logic [DATA_WIDTH-1:0] info_reg_info_field_next,
  input  logic                  info_reg_info_field_wen
);

  localparam int unsigned           ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
  localparam logic [ADDR_W-1:0]     INFO_ADDR = ADDR_W'(INFO_REG_ADDR);

  logic                  w_hit;
  access_e               w_acc;
  logic                  w_sw_we;
  logic [DATA_WIDTH-1:0] w_field;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ack;
  logic                  r_inv;

  assign w_hit   = (address == INFO_ADDR);
  assign w_acc   = decode_access(read_en, write_en, w_hit);
  assign w_sw_we = (w_acc == AccWrite);

  rf_field_reg #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_info_field (
    .clk        (clk),
    .res        (res),
    .i_sw_we    (w_sw_we),
    .i_sw_wdata (write_data),
    .i_hw_we    (info_reg_info_field_wen),
    .i_hw_wdata (info_reg_info_field_next),
    .o_value    (w_field)
  );

  // Reads sample the field before any same-cycle hardware load lands.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rdata <= '0;
    end else begin
      case (w_acc)
        AccRead:    r_rdata <= w_field;
        AccInvalid: r_rdata <= '0;
        default: begin
`ifdef SINGLERF_RDATA_CLEAR_EN
          r_rdata <= '0;
`else
          r_rdata <= r_rdata;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ack <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      r_ack <= (w_acc != AccNone);
      r_inv <= (w_acc == AccInvalid);
    end
  end

  assign read_data           = r_rdata;
  assign access_complete     = r_ack;
  assign invalid_address     = r_inv;
  assign info_reg_info_field = w_field;

endmodule

// File: tb/tb_single_rf.sv
// Directed bench for single_rf: per-cycle model comparison plus literal checkpoints.
module tb_single_rf;
  import single_rf_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [3:3]  address = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  info_field_t write_data = '0;
  info_field_t read_data;
  logic        access_complete;
  logic        invalid_address;
  info_field_t info_field;
  info_field_t hw_next = '0;
  logic        hw_wen = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  single_rf dut (
    .clk                      (clk),
    .res                      (res),
    .address                  (address),
    .read_en                  (read_en),
    .write_en                 (write_en),
    .write_data               (write_data),
    .read_data                (read_data),
    .access_complete          (access_complete),
    .invalid_address          (invalid_address),
    .info_reg_info_field      (info_field),
    .info_reg_info_field_next (hw_next),
    .info_reg_info_field_wen  (hw_wen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the register and bus response.
  info_field_t m_field = RESET_VALUE;
  info_field_t m_rd    = '0;
  logic        m_ack   = 1'b0;
  logic        m_inv   = 1'b0;

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_field <= RESET_VALUE;
      m_rd    <= '0;
      m_ack   <= 1'b0;
      m_inv   <= 1'b0;
    end else begin
      logic        any;
      logic        hit;
      info_field_t f;
      info_field_t rd;
      any = read_en || write_en;
      hit = (address == 1'b0);
      f   = m_field;
      rd  = m_rd;
`ifdef SINGLERF_RDATA_CLEAR_EN
      rd = '0;
`endif
      if (any && !hit)                rd = '0;
      else if (read_en && !write_en)  rd = m_field;
      if (write_en && hit)            f = write_data;
      else if (hw_wen)                f = hw_next;
      m_field <= f;
      m_rd    <= rd;
      m_ack   <= any;
      m_inv   <= any && !hit;
    end
  end

  always @(negedge clk) begin
    check("model_field", info_field, m_field);
    check("model_rdata", read_data, m_rd);
    check("model_ack", {63'b0, access_complete}, {63'b0, m_ack});
    check("model_inv", {63'b0, invalid_address}, {63'b0, m_inv});
  end

  // Drive one cycle of stimulus at the falling edge; return just after the rising edge.
  task automatic apply(input logic rd, input logic wr, input logic a, input logic [63:0] wd,
                       input logic hwe, input logic [63:0] hwn);
    @(negedge clk);
    read_en    = rd;
    write_en   = wr;
    address    = a;
    write_data = wd;
    hw_wen     = hwe;
    hw_next    = hwn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  initial begin
    logic [63:0] exp_hold;
    repeat (4) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    #1;
    check("reset_field", info_field, 64'h0);
    check("reset_ack", {63'b0, access_complete}, 64'h0);
    check("reset_inv", {63'b0, invalid_address}, 64'h0);
    check("reset_rdata", read_data, 64'h0);

    apply(1'b0, 1'b1, 1'b0, 64'h555AAA555AAA555A, 1'b0, 64'h0);
    check("sw_write_field", info_field, 64'h555AAA555AAA555A);
    check("sw_write_ack", {63'b0, access_complete}, 64'h1);

    apply(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    check("read_back", read_data, 64'h555AAA555AAA555A);

    apply(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0);
    check("hw_load_field", info_field, 64'h0);
    check("hw_load_no_ack", {63'b0, access_complete}, 64'h0);
    apply(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    check("read_zero_ack", {63'b0, access_complete}, 64'h1);
    check("read_zero_data", read_data, 64'h0);

    apply(1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0);
    apply(1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0);
    check("inv_flag", {63'b0, invalid_address}, 64'h1);
    check("inv_ack", {63'b0, access_complete}, 64'h1);
    check("inv_rdata", read_data, 64'h0);
    check("inv_field", info_field, 64'hDEAD_BEEF_0000_0001);
    apply(1'b0, 1'b1, 1'b1, 64'hFFFF, 1'b0, 64'h0);
    check("inv_write_field", info_field, 64'hDEAD_BEEF_0000_0001);

    apply(1'b0, 1'b1, 1'b0, 64'h1, 1'b1, 64'h2);
    check("collision_field", info_field, 64'h1);

    // Read with concurrent hw load returns the pre-load value.
    apply(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h77);
    check("read_hwload_data", read_data, 64'h1);
    check("read_hwload_field", info_field, 64'h77);

    // Read+write together acts as a write; read_data keeps its prior value when not clearing.
    apply(1'b1, 1'b1, 1'b0, 64'hABCD, 1'b0, 64'h0);
    check("rw_field", info_field, 64'hABCD);

    apply(1'b0, 1'b1, 1'b0, 64'h1234, 1'b0, 64'h0);
    apply(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    check("b2b_ack", {63'b0, access_complete}, 64'h1);
    check("read_1234", read_data, 64'h1234);
    idle();
`ifdef SINGLERF_RDATA_CLEAR_EN
    exp_hold = 64'h0;
`else
    exp_hold = 64'h1234;
`endif
    check("rdata_after_idle", read_data, exp_hold);

    apply(1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0);
    check("pre_reset_ack", {63'b0, access_complete}, 64'h1);
    #2;
    res = 1'b1;
    #1;
    check("mid_reset_ack", {63'b0, access_complete}, 64'h0);
    check("mid_reset_inv", {63'b0, invalid_address}, 64'h0);
    check("mid_reset_field", info_field, 64'h0);
    @(negedge clk);
    res      = 1'b0;
    read_en  = 1'b0;
    address  = 1'b0;
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
